// File: rtl/int2flt_seq.sv
// Memory-mapped integer-to-half-float sequencer: fetches a sign+magnitude operand,
// normalises one bit per clock, rounds to nearest-even and writes the half back.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a start request, no job has completed
// RD_HI   | operand high byte on the bus, latch sign and mag[14:8]
// RD_LO   | operand low byte on the bus, latch mag[7:0], zero shortcut
// NORM    | shift magnitude left until bit 14 is set, one bit per clock
// ROUND   | round-to-nearest-even on the normalised magnitude
// WR_HI   | result high byte {sign, exp, mant[9:8]} on the write port
// WR_LO   | result low byte mant[7:0] on the write port
// DONE    | result in memory, done held until the next accepted start
module int2flt_seq #(
    parameter int ADDR_W   = 8,
    parameter int SRC_ADDR = 0,
    parameter int DST_ADDR = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_HI,
        S_RD_LO,
        S_NORM,
        S_ROUND,
        S_WR_HI,
        S_WR_LO,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] SRC_HI = ADDR_W'(SRC_ADDR);
    localparam logic [ADDR_W-1:0] SRC_LO = ADDR_W'(SRC_ADDR + 1);
    localparam logic [ADDR_W-1:0] DST_HI = ADDR_W'(DST_ADDR);
    localparam logic [ADDR_W-1:0] DST_LO = ADDR_W'(DST_ADDR + 1);
    localparam logic [4:0]        EXP_INIT = 5'd29;

    state_t      state;
    logic        req_q;
    logic        sign;
    logic [14:0] mag;
    logic [4:0]  exp;
    logic [9:0]  mant;

    logic        start;
    logic        round_up;
    logic [10:0] mant_sum;
    logic        carry;
    logic [4:0]  exp_rnd;
    logic [9:0]  mant_rnd;
    logic [14:0] mag_full;

    assign start = req & ~req_q;

    // Bit 14 is always set in ROUND, so the significand overflows to 2048
    // exactly when the 10 fraction bits overflow.
    assign round_up = mag[3] & (mag[4] | (|mag[2:0]));
    assign mant_sum = {1'b0, mag[13:4]} + {10'd0, round_up};
    assign carry    = mant_sum[10];
    assign mant_rnd = mant_sum[9:0];
    assign exp_rnd  = carry ? exp + 5'd1 : exp;

    assign mag_full = {mag[14:8], mem_rd_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            req_q       <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
            mem_addr    <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= 8'd0;
            sign        <= 1'b0;
            mag         <= 15'd0;
            exp         <= 5'd0;
            mant        <= 10'd0;
        end else begin
            req_q       <= req;
            mem_addr    <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= 8'd0;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= S_RD_HI;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        mem_addr <= SRC_HI;
                    end
                end

                S_RD_HI: begin
                    sign      <= mem_rd_data[7];
                    mag[14:8] <= mem_rd_data[6:0];
                    state     <= S_RD_LO;
                    mem_addr  <= SRC_LO;
                end

                S_RD_LO: begin
                    mag[7:0] <= mem_rd_data;
                    if (mag_full == 15'd0) begin
                        exp         <= 5'd0;
                        mant        <= 10'd0;
                        state       <= S_WR_HI;
                        mem_addr    <= DST_HI;
                        mem_wr_en   <= 1'b1;
                        mem_wr_data <= {sign, 7'd0};
                    end else begin
                        exp   <= EXP_INIT;
                        state <= S_NORM;
                    end
                end

                S_NORM: begin
                    if (!mag[14]) begin
                        mag <= {mag[13:0], 1'b0};
                        exp <= exp - 5'd1;
                    end else begin
                        state <= S_ROUND;
                    end
                end

                S_ROUND: begin
                    exp         <= exp_rnd;
                    mant        <= mant_rnd;
                    state       <= S_WR_HI;
                    mem_addr    <= DST_HI;
                    mem_wr_en   <= 1'b1;
                    mem_wr_data <= {sign, exp_rnd, mant_rnd[9:8]};
                end

                S_WR_HI: begin
                    state       <= S_WR_LO;
                    mem_addr    <= DST_LO;
                    mem_wr_en   <= 1'b1;
                    mem_wr_data <= mant[7:0];
                end

                S_WR_LO: begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int2flt_seq.sv
// Bench for int2flt_seq: table vectors, random operands against an arithmetic
// half-float model, and hand sequences for req handling and mid-job reset.
module tb_int2flt_seq;

    logic       clk;
    logic       reset;
    logic       req;
    logic       done;
    logic       busy;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;

    logic [7:0] op_hi;
    logic [7:0] op_lo;
    logic [7:0] mem [0:255];
    int         wr_count;

    int total;
    int bad;

    int2flt_seq #(.ADDR_W(8), .SRC_ADDR(0), .DST_ADDR(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .done       (done),
        .busy       (busy),
        .mem_addr   (mem_addr),
        .mem_rd_data(mem_rd_data),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_data(mem_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd_data = (mem_addr == 8'd0) ? op_hi :
                         (mem_addr == 8'd1) ? op_lo : mem[mem_addr];

    initial wr_count = 0;
    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem[mem_addr] <= mem_wr_data;
            wr_count      <= wr_count + 1;
        end
    end

    typedef struct {
        logic [15:0] op;
        logic [15:0] res;
        int          cyc;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp_v);
        end
    endtask

    // Reference: plain arithmetic on the integer value, round-half-to-even.
    function automatic logic [15:0] ref_half(input logic [15:0] op);
        int m, e, q, r, sh, hv, ex;
        m = int'(op[14:0]);
        if (m == 0) return {op[15], 15'd0};
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        ex = e + 15;
        if (e <= 10) begin
            q = m << (10 - e);
        end else begin
            sh = e - 10;
            q  = m >> sh;
            r  = m - (q << sh);
            hv = 1 << (sh - 1);
            if (r > hv || (r == hv && (q % 2) == 1)) q++;
            if (q == 2048) begin
                q = 1024;
                ex++;
            end
        end
        return {op[15], 5'(ex), 10'(q - 1024)};
    endfunction

    function automatic int ref_cycles(input logic [15:0] op);
        int m, e;
        m = int'(op[14:0]);
        if (m == 0) return 4;
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        return (14 - e) + 6;
    endfunction

    task automatic run_job(input logic [15:0] op, output logic [15:0] res,
                           output int cyc, output int writes);
        int  w0;
        logic to;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        w0    = wr_count;
        op_hi = op[15:8];
        op_lo = op[7:0];
        req   = 1'b1;
        cyc   = 0;
        to    = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) cyc++;
            if (done && !busy) begin
                to = 1'b0;
                break;
            end
        end
        req = 1'b0;
        if (to) begin
            bad++;
            total++;
            $display("FAIL job_timeout: op 0x%0h no done within 40 cycles", op);
        end
        res    = {mem[2], mem[3]};
        writes = wr_count - w0;
    endtask

    logic [15:0] res;
    logic [15:0] rop;
    int          cyc;
    int          writes;
    int          rises;
    int          w0;
    logic        prev_busy;
    logic        to;

    initial begin
        total = 0;
        bad   = 0;
        vecs[0] = '{16'h0001, 16'h3C00, 20};
        vecs[1] = '{16'h7FFF, 16'h7800, 6};
        vecs[2] = '{16'h000C, 16'h4A00, 17};
        vecs[3] = '{16'h1002, 16'h6C00, 8};
        vecs[4] = '{16'h1006, 16'h6C02, 8};
        vecs[5] = '{16'h1001, 16'h6C00, 8};
        vecs[6] = '{16'h8000, 16'h8000, 4};
        vecs[7] = '{16'h8001, 16'hBC00, 20};
        vecs[8] = '{16'h0003, 16'h4200, 19};
        vecs[9] = '{16'h4000, 16'h7400, 6};

        reset = 1'b1;
        req   = 1'b0;
        op_hi = 8'd0;
        op_lo = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_done", int'(done), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_wr_en", int'(mem_wr_en), 0);
        chk("reset_addr", int'(mem_addr), 0);
        chk("reset_wr_data", int'(mem_wr_data), 0);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_job(vecs[i].op, res, cyc, writes);
            chk($sformatf("vec%0d_result", i), int'(res), int'(vecs[i].res));
            chk($sformatf("vec%0d_cycles", i), cyc, vecs[i].cyc);
            chk($sformatf("vec%0d_writes", i), writes, 2);
        end

        for (int i = 0; i < 40; i++) begin
            rop = 16'($urandom_range(0, 65535));
            if (i % 8 == 0) rop[14:0] = 15'($urandom_range(0, 7));
            run_job(rop, res, cyc, writes);
            chk($sformatf("rand_result_op%0h", rop), int'(res), int'(ref_half(rop)));
            chk($sformatf("rand_cycles_op%0h", rop), cyc, ref_cycles(rop));
        end

        // req held high for 30 cycles must start exactly one job
        @(negedge clk);
        req   = 1'b0;
        op_hi = 8'h80;
        op_lo = 8'h00;
        @(negedge clk);
        w0        = wr_count;
        rises     = 0;
        prev_busy = busy;
        req       = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy && !prev_busy) rises++;
            prev_busy = busy;
        end
        chk("hold_jobs", rises, 1);
        chk("hold_writes", wr_count - w0, 2);
        chk("hold_done", int'(done), 1);
        chk("hold_result", int'({mem[2], mem[3]}), 16'h8000);
        req = 1'b0;

        // second req edge while busy is ignored
        @(negedge clk);
        op_hi = 8'h00;
        op_lo = 8'h01;
        @(negedge clk);
        w0  = wr_count;
        req = 1'b1;
        cyc = 0;
        to  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) cyc++;
            if (i == 3) req = 1'b0;
            if (i == 5) req = 1'b1;
            if (i == 7) req = 1'b0;
            if (done && !busy) begin
                to = 1'b0;
                break;
            end
        end
        chk("busy_edge_timeout", int'(to), 0);
        chk("busy_edge_cycles", cyc, 20);
        rises = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy) rises++;
        end
        chk("busy_edge_no_rerun", rises, 0);
        chk("busy_edge_done", int'(done), 1);
        chk("busy_edge_writes", wr_count - w0, 2);

        // reset while normalising 0x0003, req kept high across reset
        @(negedge clk);
        op_hi = 8'h00;
        op_lo = 8'h03;
        @(negedge clk);
        w0  = wr_count;
        req = 1'b1;
        repeat (5) @(negedge clk);
        chk("pre_reset_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        chk("mid_reset_busy", int'(busy), 0);
        chk("mid_reset_done", int'(done), 0);
        chk("mid_reset_wr_en", int'(mem_wr_en), 0);
        repeat (3) @(negedge clk);
        chk("mid_reset_no_writes", wr_count - w0, 0);
        chk("mid_reset_done_held", int'(done), 0);
        reset = 1'b0;
        cyc = 0;
        to  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) cyc++;
            if (done && !busy) begin
                to = 1'b0;
                break;
            end
        end
        req = 1'b0;
        chk("after_reset_timeout", int'(to), 0);
        chk("after_reset_cycles", cyc, 19);
        chk("after_reset_result", int'({mem[2], mem[3]}), 16'h4200);
        chk("after_reset_writes", wr_count - w0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
